// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, redirect from execute,
// and the decode-side valid/stall port, grouped for one connection.
interface instr_fetch_queue_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Stall;
    logic        InstValid;
    logic [31:0] Instruction;
    logic [31:0] InstPC;

    // The fetch unit drives memory requests and the decode head.
    modport master (
        output IMemReq, IMemAddr, InstValid, Instruction, InstPC,
        input  IMemAck, IMemData, Redirect, RedirectPC, Stall
    );

    // Memory, execute and decode side of the same bus.
    modport slave (
        input  IMemReq, IMemAddr, InstValid, Instruction, InstPC,
        output IMemAck, IMemData, Redirect, RedirectPC, Stall
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: sequential prefetch into a DEPTH-entry FIFO,
// head presented to decode with valid/stall, flush-and-refetch on redirect.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset,
    instr_fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_word [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc;

    // Redirect wins over push and pop; acked data in a redirect cycle is dropped.
    assign push        = (state == REQ) && bus.IMemAck && !bus.Redirect;
    assign pop         = (count != '0) && !bus.Stall && !bus.Redirect;
    assign redirect_pc = bus.RedirectPC & 32'hFFFF_FFFC;

    // Occupancy after this cycle's push/pop, used to decide whether to keep fetching.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Fetch FSM, fetch PC, request address and FIFO pointers. req_addr is kept
    // separate from fetch_pc so a request pending across a redirect keeps its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (bus.Redirect) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= redirect_pc;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    req_addr <= redirect_pc;
                end
                REQ: begin
                    if (bus.IMemAck) begin
                        state    <= REQ;
                        req_addr <= redirect_pc;
                    end else begin
                        state    <= DROP;
                    end
                end
                DROP: begin
                    // The old request is still owed an ack; a new target just replaces
                    // the pending one. If it completes now, the next one is dropped too.
                    state <= DROP;
                    if (bus.IMemAck) req_addr <= redirect_pc;
                end
                default: state <= IDLE;
            endcase
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case (state)
                IDLE: begin
                    if (count < FULL) state <= REQ;
                end
                REQ: begin
                    if (bus.IMemAck) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        req_addr <= fetch_pc + 32'd4;
                        state    <= (count_next < FULL) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (bus.IMemAck) begin
                        state    <= REQ;
                        req_addr <= fetch_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents are only observed through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= bus.IMemData;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.IMemReq     = (state == REQ) || (state == DROP);
    assign bus.IMemAddr    = req_addr;
    assign bus.InstValid   = (count != '0);
    assign bus.Instruction = bus.InstValid ? mem_word[rd_ptr] : 32'h0;
    assign bus.InstPC      = bus.InstValid ? mem_pc[rd_ptr]   : 32'h0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming fetch, full FIFO under stall,
// redirect with slow memory, redirect on ack, PC wrap, reset mid-request.
module tb_instr_fetch_queue;
    logic clk;
    logic reset;
    logic ack;
    logic redirect;
    logic [31:0] redirect_pc;
    logic stall;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_queue_if bus ();
    instr_fetch_queue_if bus5 ();

    // Instruction memory returns address ^ 5A5A0000 so every word is traceable.
    assign bus.IMemAck     = ack;
    assign bus.IMemData    = bus.IMemAddr ^ 32'h5A5A_0000;
    assign bus.Redirect    = redirect;
    assign bus.RedirectPC  = redirect_pc;
    assign bus.Stall       = stall;

    assign bus5.IMemAck    = 1'b1;
    assign bus5.IMemData   = bus5.IMemAddr ^ 32'h5A5A_0000;
    assign bus5.Redirect   = 1'b0;
    assign bus5.RedirectPC = 32'h0;
    assign bus5.Stall      = 1'b0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] word);
        chk({tag, "_valid"}, {31'h0, bus.InstValid}, {31'h0, v});
        chk({tag, "_pc"},    bus.InstPC,      pc);
        chk({tag, "_word"},  bus.Instruction, word);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ack         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_req",  {31'h0, bus.IMemReq}, 32'h0);
        chk("rst_addr", bus.IMemAddr, 32'h0);
        chk_head("rst", 1'b0, 32'h0, 32'h0);

        // 1: zero-wait streaming
        ack = 1'b1;
        reset = 1'b0;
        tick();
        chk("t1_req",   {31'h0, bus.IMemReq}, 32'h1);
        chk("t1_addr0", bus.IMemAddr, 32'h0);
        chk_head("t1_e1", 1'b0, 32'h0, 32'h0);
        tick();
        chk_head("t1_e2", 1'b1, 32'h0, 32'h5A5A_0000);
        chk("t1_addr4", bus.IMemAddr, 32'h4);
        tick();
        chk_head("t1_e3", 1'b1, 32'h4, 32'h5A5A_0004);
        chk("t1_addr8", bus.IMemAddr, 32'h8);
        tick();
        chk_head("t1_e4", 1'b1, 32'h8, 32'h5A5A_0008);
        chk("t1_addrC", bus.IMemAddr, 32'hC);

        // 2: stall fills the FIFO, then drain in order
        stall = 1'b1;
        do_reset();
        repeat (5) tick();
        chk("t2_req_off", {31'h0, bus.IMemReq}, 32'h0);
        chk_head("t2_full", 1'b1, 32'h0, 32'h5A5A_0000);
        chk("t2_addr10", bus.IMemAddr, 32'h10);
        tick();
        chk("t2_req_off2", {31'h0, bus.IMemReq}, 32'h0);
        chk_head("t2_hold", 1'b1, 32'h0, 32'h5A5A_0000);
        stall = 1'b0;
        tick();
        chk_head("t2_pop4", 1'b1, 32'h4, 32'h5A5A_0004);
        chk("t2_req_idle", {31'h0, bus.IMemReq}, 32'h0);
        tick();
        chk_head("t2_pop8", 1'b1, 32'h8, 32'h5A5A_0008);
        chk("t2_req_on", {31'h0, bus.IMemReq}, 32'h1);
        chk("t2_resume", bus.IMemAddr, 32'h10);
        tick();
        chk_head("t2_popC", 1'b1, 32'hC, 32'h5A5A_000C);
        tick();
        chk_head("t2_pop10", 1'b1, 32'h10, 32'h5A5A_0010);

        // 3: 3-cycle memory, redirect while 0x8 is outstanding
        ack = 1'b0;
        do_reset();
        tick();
        tick(); tick(); ack = 1'b1; tick(); ack = 1'b0;
        chk_head("t3_w0", 1'b1, 32'h0, 32'h5A5A_0000);
        tick(); tick(); ack = 1'b1; tick(); ack = 1'b0;
        chk_head("t3_w4", 1'b1, 32'h4, 32'h5A5A_0004);
        chk("t3_addr8", bus.IMemAddr, 32'h8);
        tick();
        chk_head("t3_empty", 1'b0, 32'h0, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0101;
        tick();
        redirect = 1'b0;
        chk("t3_drop_req",  {31'h0, bus.IMemReq}, 32'h1);
        chk("t3_drop_addr", bus.IMemAddr, 32'h8);
        tick();
        chk("t3_drop_hold", bus.IMemAddr, 32'h8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_head("t3_discard", 1'b0, 32'h0, 32'h0);
        chk("t3_addr100", bus.IMemAddr, 32'h100);
        chk("t3_req100",  {31'h0, bus.IMemReq}, 32'h1);
        tick(); tick(); ack = 1'b1; tick(); ack = 1'b0;
        chk_head("t3_w100", 1'b1, 32'h100, 32'h5A5A_0100);

        // 4: redirect in the same cycle as ack for 0x10 and a pop
        ack = 1'b1;
        do_reset();
        repeat (5) tick();
        chk("t4_addr10", bus.IMemAddr, 32'h10);
        chk_head("t4_headC", 1'b1, 32'hC, 32'h5A5A_000C);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk_head("t4_flush", 1'b0, 32'h0, 32'h0);
        chk("t4_addr200", bus.IMemAddr, 32'h200);
        tick();
        chk_head("t4_w200", 1'b1, 32'h200, 32'h5A5A_0200);

        // 6: reset mid-request with two entries held
        stall = 1'b1;
        do_reset();
        tick(); tick(); tick();
        chk("t6_req_pre", {31'h0, bus.IMemReq}, 32'h1);
        chk_head("t6_pre", 1'b1, 32'h0, 32'h5A5A_0000);
        reset = 1'b1;
        #1;
        chk("t6_req_async", {31'h0, bus.IMemReq}, 32'h0);
        chk_head("t6_async", 1'b0, 32'h0, 32'h0);
        tick();
        chk("t6_req_rst",  {31'h0, bus.IMemReq}, 32'h0);
        chk("t6_addr_rst", bus.IMemAddr, 32'h0);
        chk_head("t6_rst", 1'b0, 32'h0, 32'h0);
        stall = 1'b0;
        ack   = 1'b0;
        reset = 1'b0;
        tick();
        chk("t6_addr_first", bus.IMemAddr, 32'h0);
        chk("t6_req_first",  {31'h0, bus.IMemReq}, 32'h1);
        chk_head("t6_nostale", 1'b0, 32'h0, 32'h0);

        // 5: RESET_PC near the top wraps to 0 (second instance, zero-wait)
        chk("t5_addr0", bus5.IMemAddr, 32'hFFFF_FFF8);
        chk("t5_req",   {31'h0, bus5.IMemReq}, 32'h1);
        ack = 1'b1;
        tick();
        chk_head("t6_w0", 1'b1, 32'h0, 32'h5A5A_0000);
        chk("t5_addr1", bus5.IMemAddr, 32'hFFFF_FFFC);
        chk("t5_pc0",   bus5.InstPC, 32'hFFFF_FFF8);
        chk("t5_word0", bus5.Instruction, 32'hA5A5_FFF8);
        tick();
        chk("t5_addr2", bus5.IMemAddr, 32'h0000_0000);
        chk("t5_pc1",   bus5.InstPC, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr3", bus5.IMemAddr, 32'h0000_0004);
        chk("t5_pc2",   bus5.InstPC, 32'h0000_0000);
        chk("t5_word2", bus5.Instruction, 32'h5A5A_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
